// File: rtl/alu_disp_pkg.sv
// -----------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU-result display path: converter FSM states,
// default datapath sizes and the ALU divide-by-zero sentinel value.
// -----------------------------------------------------------------------------
package alu_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALU_W      = 32;
    localparam int BCD_DIGITS = 10;

    // All-ones ALU result; the ALU emits this on divide by zero.
    localparam logic [ALU_W-1:0] ERR_SENTINEL = 32'hFFFF_FFFF;

    // Smallest digit count able to hold 2**width-1, i.e. ceil(width*log10(2)).
    // log10(2) is approximated as 0.30103, which is exact enough for any
    // practical ALU width.
    function automatic int bcd_min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage : alu_disp_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational add-3 correction for one BCD digit of the double-dabble
// converter: a digit of 5 or more gets +3 so that the following left shift
// carries correctly into the next decimal digit.
//
// Ports:
//   din  - 4-bit BCD digit before correction
//   dout - corrected digit (din >= 5 ? din + 3 : din)
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
// clock). Takes the ALU result over a valid/ready handshake, converts it in
// WIDTH cycles and presents packed BCD digits, a leading-zero significance
// mask and the divide-by-zero error flag to the 7-segment display driver.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_data   - binary value to convert (ALU result)
//   in_valid  - in_data is valid
//   in_ready  - converter can accept (high only in IDLE)
//   bcd       - packed BCD result, digit 0 (units) in bcd[3:0]
//   digit_nz  - digit_nz[i] = 1 when digit i or any higher digit is nonzero;
//               digit_nz[0] is always 1 so zero displays as "0"
//   err       - captured input was the all-ones error sentinel
//   out_valid - bcd / digit_nz / err are valid
//   out_ready - downstream accepts the result
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import alu_disp_pkg::*;
#(
    parameter int WIDTH      = ALU_W,
    parameter int DIGITS     = BCD_DIGITS,
    parameter bit ERR_DETECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_nz,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Elaboration-time sanity: too few digits would silently overflow.
    if (DIGITS < bcd_min_digits(WIDTH)) begin : g_digits_too_small
        $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end
    if (WIDTH < 2) begin : g_width_too_small
        $error("bin_to_bcd_seq: WIDTH must be at least 2");
    end

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [BCD_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_cap_q,   err_cap_d;
    logic [BCD_W-1:0]   bcd_q,       bcd_d;
    logic [DIGITS-1:0]  digit_nz_q,  digit_nz_d;
    logic               err_q,       err_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_shift;
    logic [WIDTH-1:0]   shreg_shift;
    logic [DIGITS-1:0]  nz_mask;
    logic               nz_seen;

    // Per-digit add-3 correction, applied before this cycle's shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc_q[4*gi +: 4]),
            .dout (acc_adj[4*gi +: 4])
        );
    end

    // The shreg MSB shifts into the BCD units digit.
    assign acc_shift   = {acc_adj[BCD_W-2:0], shreg_q[WIDTH-1]};
    assign shreg_shift = {shreg_q[WIDTH-2:0], 1'b0};

    // Significance mask of the post-shift accumulator, scanned from the
    // most significant digit down.
    always_comb begin
        nz_mask = '0;
        nz_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen    = nz_seen | (acc_shift[4*i +: 4] != 4'd0);
            nz_mask[i] = nz_seen;
        end
        nz_mask[0] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_cap_d   = err_cap_q;
        bcd_d       = bcd_q;
        digit_nz_d  = digit_nz_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    acc_d     = '0;
                    cnt_d     = '0;
                    err_cap_d = ERR_DETECT && (in_data == {WIDTH{1'b1}});
                    state_d   = CONV;
                end
            end
            CONV: begin
                acc_d   = acc_shift;
                shreg_d = shreg_shift;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d       = acc_shift;
                    digit_nz_d  = nz_mask;
                    err_d       = err_cap_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_cap_q   <= 1'b0;
            bcd_q       <= '0;
            digit_nz_q  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_cap_q   <= err_cap_d;
            bcd_q       <= bcd_d;
            digit_nz_q  <= digit_nz_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign bcd       = bcd_q;
    assign digit_nz  = digit_nz_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule : bin_to_bcd_seq

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that consumes the 32-bit ALU result and produces packed BCD digits for the 7-segment display path.
Sits between the ALU result register and the display driver, with a valid/ready handshake on both sides.
Also flags the ALU all-ones error sentinel (divide by zero) so the display can show an error pattern instead of digits.

Parameters:
WIDTH, 32, binary input width in bits.
DIGITS, 10, number of BCD output digits; must be at least ceil(WIDTH*log10(2)), which is 10 for WIDTH=32.
ERR_DETECT, 1, when 1 the all-ones input raises err; when 0, err is tied to 0.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  WIDTH  binary value to convert (ALU result).
in_valid  in  1  in_data is valid.
in_ready  out  1  converter can accept; high only in IDLE.
bcd  out  4*DIGITS  packed BCD; digit 0 (units) is bcd[3:0].
digit_nz  out  DIGITS  per-digit significance mask for leading-zero blanking.
err  out  1  captured input was all ones (error sentinel).
out_valid  out  1  bcd/digit_nz/err are valid.
out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (async assert, sync release): state=IDLE; bcd=0, digit_nz=0, err=0, out_valid=0, in_ready=1, shift register and counter cleared.
- Reset asserted mid-conversion or during DONE aborts immediately; the partial result is discarded, with no output pulse.
- States:
  - IDLE: in_ready=1. On in_valid at an edge: capture in_data into the shift register, clear the BCD accumulator, cnt=0, err_q=(ERR_DETECT && in_data=={WIDTH{1'b1}}), go to CONV.
  - CONV: in_ready=0. Each edge: every BCD digit >=5 gets +3, then {acc,shreg} shifts left by 1; cnt++. On the edge where cnt==WIDTH-1: load bcd, digit_nz and err from the final values, set out_valid=1, go to DONE.
  - DONE: outputs held stable while out_valid=1. On an edge with out_ready=1: out_valid=0, go to IDLE. bcd, digit_nz and err keep their last value until the next load.
- Latency: out_valid rises exactly WIDTH clock edges after the capture edge (32 for the default).
- Throughput is one conversion per WIDTH+2 cycles minimum: capture, WIDTH cycles, one DONE handshake cycle, then back to IDLE.
- in_valid is ignored outside IDLE; in_data is not sampled again until the next IDLE capture.
- out_ready while out_valid=0 has no effect.
- digit_nz[i]=1 iff digit i or any higher digit is nonzero. digit_nz[0] is always 1, so the value 0 displays as "0".
- The conversion is still performed for the error sentinel: bcd=4294967295 and err=1. The display path decides the presentation.
- Add-3 is applied before the shift in each cycle. It is never applied after the final shift.
- No overflow is possible when the DIGITS constraint holds. An elaboration-time check fails if DIGITS is too small.

Decomposition:
- Shared package alu_disp_pkg holds:
  - state enum {IDLE, CONV, DONE};
  - ALU_W=32 and BCD_DIGITS=10;
  - ERR_SENTINEL=32'hFFFFFFFF, which is also the value the ALU emits on divide by zero.
- One natural sub-module, bcd_add3: a combinational 4-bit in, 4-bit out correction (in>=5 ? in+3 : in). It is instantiated DIGITS times in a generate loop.
- The top level contains the FSM, counter, shift register, output registers and the nz mask.

Test Plan:
- Reset, then in_data=0 -> out_valid rises 32 cycles after capture; bcd=0, digit_nz=10'b0000000001, err=0.
- in_data=255 -> bcd=40'h0000000255, digit_nz=10'b0000000111.
- in_data=32'hFFFFFFFF -> bcd=40'h4294967295, err=1, digit_nz=all ones. With ERR_DETECT=0, err=0.
- in_data=1000000000 with out_ready held 0 for 20 cycles -> out_valid and bcd=40'h1000000000 stay stable; in_ready=0 throughout; a new in_valid is ignored. On out_ready=1 the block returns to IDLE and in_ready=1 on the next cycle.
- Start in_data=65535*65535 (4294836225), assert rst_n=0 at cycle 10 of CONV -> all outputs 0 immediately, in_ready=1. A subsequent conversion of 12345 yields bcd=40'h0000012345.
- Back-to-back: two inputs (7, 99999) with out_ready tied high -> two results in order, 34 cycles apart, with digit_nz=10'b0000000001 and 10'b0000011111 respectively.
